// File: rtl/blink_pkg.sv
// blink_pkg: definitions shared by event_blinker and its tick generator.
//  - blink_state_e : 2-bit FSM encoding (ST_IDLE / ST_ON / ST_GAP)
//  - params_valid  : range check applied to the blinker parameters at elaboration
//  - max_int       : helper used to size the phase counter
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } blink_state_e;

  localparam int MIN_TICK_DIV  = 2;
  localparam int MIN_ON_TICKS  = 1;
  localparam int MIN_GAP_TICKS = 1;
  localparam int MIN_PEND_W    = 1;

  function automatic bit params_valid(input int tick_div, input int on_ticks,
                                      input int gap_ticks, input int pend_w);
    return (tick_div >= MIN_TICK_DIV) && (on_ticks >= MIN_ON_TICKS) &&
           (gap_ticks >= MIN_GAP_TICKS) && (pend_w >= MIN_PEND_W);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running 0..TICK_DIV-1 counter with a synchronous restart.
// Ports:
//  sysclk  in  system clock (rising edge)
//  reset_n in  asynchronous active-low reset
//  restart in  forces the counter to 0 on the next edge
//  tick    out high in the last cycle of each TICK_DIV-cycle period
module tick_gen
  import blink_pkg::*;
#(
  parameter int TICK_DIV = 20
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: restart wins, otherwise wrap at the end of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // Counter register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/event_blinker.sv
// event_blinker: turns single-cycle event pulses into visible LED blinks.
// Every accepted event produces one blink of ON_TICKS ticks lit followed by
// GAP_TICKS ticks dark; events arriving while busy are queued in a saturating
// pending counter.
// Ports:
//  sysclk   in  system clock (rising edge)
//  reset_n  in  asynchronous active-low reset
//  event_in in  single-cycle event pulse ("event" is a reserved word in SV)
//  clear    in  synchronous flush: abort blink, drop the queue
//  led      out blink output (registered)
//  busy     out high while not idle (registered)
//  pending  out queued events not yet started (registered)
//  overflow out one-cycle pulse when an event was dropped (registered)
module event_blinker
  import blink_pkg::*;
#(
  parameter int TICK_DIV  = 20,
  parameter int ON_TICKS  = 4,
  parameter int GAP_TICKS = 2,
  parameter int PEND_W    = 3
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              event_in,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  if (!params_valid(TICK_DIV, ON_TICKS, GAP_TICKS, PEND_W)) begin : g_bad_params
    $error("event_blinker: parameter out of range");
  end

  localparam int                PH_MAX   = max_int(ON_TICKS, GAP_TICKS);
  localparam int                PH_W     = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  blink_state_e      state_d, state_q;
  logic [PH_W-1:0]   phase_d, phase_q;
  logic [PEND_W-1:0] pending_d, pending_q;
  logic              led_d, led_q;
  logic              busy_d, busy_q;
  logic              ovf_d, ovf_q;
  logic              tick;
  logic              restart;
  logic              phase_end;
  logic              start;
  logic              want;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .restart(restart),
    .tick   (tick)
  );

  // Next-state, phase counter and pending-queue logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    ovf_d     = 1'b0;
    phase_end = 1'b0;
    start     = 1'b0;
    want      = event_in || (pending_q != '0);

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (want) begin
          start   = 1'b1;
          state_d = ST_ON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (tick && (phase_q == ON_LAST)) begin
          phase_end = 1'b1;
          phase_d   = '0;
          state_d   = ST_GAP;
        end else if (tick) begin
          phase_d = phase_q + PH_W'(1'b1);
        end else begin
          phase_d = phase_q;
        end
      end
      ST_GAP: begin
        if (tick && (phase_q == GAP_LAST)) begin
          phase_end = 1'b1;
          phase_d   = '0;
          // Back-to-back blink: go straight to ON without an IDLE cycle.
          if (want) begin
            start   = 1'b1;
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          phase_d = phase_q + PH_W'(1'b1);
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    // A blink start consumes one request: the queue head if there is one
    // (a same-cycle event then refills it), otherwise the event itself.
    if (start) begin
      if ((pending_q != '0) && !event_in) begin
        pending_d = pending_q - PEND_W'(1'b1);
      end else begin
        pending_d = pending_q;
      end
    end else if (event_in) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + PEND_W'(1'b1);
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end

    if (clear) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      pending_d = '0;
      ovf_d     = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Holding the tick counter at 0 while idle makes the first ON phase exact.
    restart = clear || phase_end || (state_q == ST_IDLE);
    led_d   = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      pending_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: table-driven directed scenarios, a hand-written
// asynchronous-reset sequence and a randomized run, all compared against a
// cycle-countdown reference model.
module tb_event_blinker;

  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int GPT  = 1;
  localparam int PW   = 2;
  localparam int PMAX = 3;
  localparam int M_IDLE = 0;
  localparam int M_ON   = 1;
  localparam int M_GAP  = 2;
  localparam int SCEN_LEN = 72;

  logic          sysclk   = 1'b0;
  logic          reset_n  = 1'b1;
  logic          event_in = 1'b0;
  logic          clear    = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 sysclk = ~sysclk;

  event_blinker #(
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .GAP_TICKS(GPT),
    .PEND_W   (PW)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .event_in(event_in),
    .clear   (clear),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int blinks   = 0;
  bit prev_led = 1'b0;

  // Reference model: mode plus cycles left in the current phase.
  int m_mode, m_left, m_pend;
  bit m_ovf;

  typedef struct {
    int scen;
    int cyc;
    bit led;
    bit busy;
    int pend;
    bit ovf;
  } cp_t;

  typedef struct {
    logic [63:0] ev;
    logic [63:0] clr;
    int          blinks;
  } scen_t;

  cp_t   cps[$];
  scen_t scens[5];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void add_cp(input int s, input int c, input bit l, input bit b,
                                 input int p, input bit o);
    cps.push_back('{scen: s, cyc: c, led: l, busy: b, pend: p, ovf: o});
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic m_step(input bit ev, input bit clr);
    bit want;
    bit start;
    want  = ev || (m_pend != 0);
    start = 1'b0;
    m_ovf = 1'b0;
    if (clr) begin
      m_reset();
      return;
    end
    case (m_mode)
      M_IDLE: start = want;
      M_ON: begin
        if (m_left == 1) begin
          m_mode = M_GAP;
          m_left = GPT * TD;
        end else m_left--;
      end
      default: begin
        if (m_left == 1) begin
          if (want) start = 1'b1;
          else m_mode = M_IDLE;
        end else m_left--;
      end
    endcase
    if (start) begin
      m_mode = M_ON;
      m_left = ONT * TD;
      if (m_pend > 0 && !ev) m_pend--;
    end else if (ev) begin
      if (m_pend < PMAX) m_pend++;
      else m_ovf = 1'b1;
    end
  endtask

  // One clock: advance the model with the inputs of the ending cycle, then
  // compare the DUT against the model and any checkpoint for this cycle.
  task automatic step(input int scen);
    @(posedge sysclk);
    cyc++;
    if (!reset_n) m_reset();
    else m_step(event_in, clear);
    #1;
    chk("led", int'(led), int'(m_mode == M_ON));
    chk("busy", int'(busy), int'(m_mode != M_IDLE));
    chk("pending", int'(pending), m_pend);
    chk("overflow", int'(overflow), int'(m_ovf));
    foreach (cps[i]) begin
      if (cps[i].scen == scen && cps[i].cyc == cyc) begin
        chk($sformatf("s%0d_led", scen), int'(led), int'(cps[i].led));
        chk($sformatf("s%0d_busy", scen), int'(busy), int'(cps[i].busy));
        chk($sformatf("s%0d_pending", scen), int'(pending), cps[i].pend);
        chk($sformatf("s%0d_overflow", scen), int'(overflow), int'(cps[i].ovf));
      end
    end
    if (led && !prev_led) blinks++;
    prev_led = led;
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic begin_reset();
    event_in = 1'b0;
    clear    = 1'b0;
    reset_n  = 1'b0;
    cyc      = 0;
    blinks   = 0;
    prev_led = 1'b0;
    m_reset();
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  initial begin
    for (int s = 0; s < 5; s++) begin
      scens[s].ev  = '0;
      scens[s].clr = '0;
    end
    scens[0].ev[10] = 1'b1;                        scens[0].blinks = 1;
    scens[1].ev[10] = 1'b1; scens[1].ev[11] = 1'b1;
    scens[1].ev[12] = 1'b1;                        scens[1].blinks = 3;
    for (int c = 10; c <= 14; c++) scens[2].ev[c] = 1'b1;
    scens[2].blinks = 4;
    scens[3].ev[10] = 1'b1; scens[3].ev[22] = 1'b1; scens[3].blinks = 2;
    scens[4].ev[10] = 1'b1; scens[4].ev[14] = 1'b1;
    scens[4].clr[14] = 1'b1;                       scens[4].blinks = 1;

    add_cp(1, 10, 0, 0, 0, 0); add_cp(1, 11, 1, 1, 0, 0); add_cp(1, 18, 1, 1, 0, 0);
    add_cp(1, 19, 0, 1, 0, 0); add_cp(1, 22, 0, 1, 0, 0); add_cp(1, 23, 0, 0, 0, 0);
    add_cp(2, 12, 1, 1, 1, 0); add_cp(2, 13, 1, 1, 2, 0); add_cp(2, 22, 0, 1, 2, 0);
    add_cp(2, 23, 1, 1, 1, 0); add_cp(2, 35, 1, 1, 0, 0); add_cp(2, 42, 1, 1, 0, 0);
    add_cp(2, 46, 0, 1, 0, 0); add_cp(2, 47, 0, 0, 0, 0);
    add_cp(3, 14, 1, 1, 3, 0); add_cp(3, 15, 1, 1, 3, 1); add_cp(3, 16, 1, 1, 3, 0);
    add_cp(4, 22, 0, 1, 0, 0); add_cp(4, 23, 1, 1, 0, 0); add_cp(4, 30, 1, 1, 0, 0);
    add_cp(4, 31, 0, 1, 0, 0); add_cp(4, 35, 0, 0, 0, 0);
    add_cp(5, 14, 1, 1, 0, 0); add_cp(5, 15, 0, 0, 0, 0); add_cp(5, 20, 0, 0, 0, 0);

    #2;
    // Directed scenarios from the table.
    for (int s = 0; s < 5; s++) begin
      begin_reset();
      for (int c = 1; c <= SCEN_LEN; c++) begin
        step(s + 1);
        if (cyc == 2) reset_n = 1'b1;
        event_in = (cyc < 64) ? scens[s].ev[cyc] : 1'b0;
        clear    = (cyc < 64) ? scens[s].clr[cyc] : 1'b0;
      end
      chk($sformatf("s%0d_blinks", s + 1), blinks, scens[s].blinks);
    end

    // Reset asserted mid-cycle while ON with two events queued.
    begin_reset();
    for (int c = 1; c <= 14; c++) begin
      step(6);
      if (cyc == 2) reset_n = 1'b1;
      event_in = (cyc >= 10 && cyc <= 12);
    end
    chk("s6_pend_before", int'(pending), 2);
    chk("s6_led_before", int'(led), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_async_led", int'(led), 0);
    chk("s6_async_busy", int'(busy), 0);
    chk("s6_async_pending", int'(pending), 0);
    m_reset();
    blinks   = 0;
    prev_led = 1'b0;
    step(6);
    step(6);
    reset_n = 1'b1;
    step(6);
    event_in = 1'b1;
    step(6);
    event_in = 1'b0;
    chk("s6_led_after", int'(led), 1);
    for (int c = 0; c < 20; c++) step(6);
    chk("s6_blinks", blinks, 1);

    // Randomized run against the model.
    begin_reset();
    step(0);
    step(0);
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step(0);
      event_in = ($urandom_range(0, 99) < 35);
      clear    = ($urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
